// File: rtl/axi_llc_evict_dispatch.sv
// Turns one LLC eviction decision into an optional write-back descriptor followed
// by a refill descriptor, and counts accepted write-backs.
module axi_llc_evict_dispatch #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned IndexLength      = 8,
    parameter int unsigned TagLength        = 20,
    localparam int unsigned WayIdxW = (SetAssociativity > 1) ? $clog2(SetAssociativity) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        dec_valid_i,
    output logic                        dec_ready_o,
    input  logic [SetAssociativity-1:0] dec_way_ind_i,
    input  logic                        dec_evict_i,
    input  logic [IndexLength-1:0]      dec_index_i,
    input  logic [TagLength-1:0]        dec_old_tag_i,
    input  logic [TagLength-1:0]        dec_new_tag_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [WayIdxW-1:0]          wb_way_o,
    output logic [IndexLength-1:0]      wb_index_o,
    output logic [TagLength-1:0]        wb_tag_o,
    output logic                        rf_valid_o,
    input  logic                        rf_ready_i,
    output logic [WayIdxW-1:0]          rf_way_o,
    output logic [IndexLength-1:0]      rf_index_o,
    output logic [TagLength-1:0]        rf_tag_o,
    output logic                        err_o,
    output logic [31:0]                 wb_cnt_o,
    input  logic                        ctrl_clr_i
);

    typedef enum logic [1:0] {IDLE, WB, RF} state_e;

    state_e                 state_q, state_d;
    logic [WayIdxW-1:0]     way_q, way_d;
    logic [IndexLength-1:0] index_q, index_d;
    logic [TagLength-1:0]   old_tag_q, old_tag_d;
    logic [TagLength-1:0]   new_tag_q, new_tag_d;
    logic                   err_q, err_d;
    logic [31:0]            wb_cnt_q, wb_cnt_d;

    logic               way_seen, way_multi, dec_ok, dec_hs, wb_hs;
    logic [WayIdxW-1:0] way_enc;

    // One-hot check and binary encode of the chosen way in a single scan.
    always_comb begin
        way_seen  = 1'b0;
        way_multi = 1'b0;
        way_enc   = '0;
        for (int i = 0; i < int'(SetAssociativity); i++) begin
            if (dec_way_ind_i[i]) begin
                way_multi = way_multi | way_seen;
                way_seen  = 1'b1;
                if (SetAssociativity > 1) way_enc = WayIdxW'(i);
            end
        end
    end

    assign dec_ok = way_seen & ~way_multi;
    assign dec_hs = dec_ready_o & dec_valid_i;
    assign wb_hs  = wb_valid_o & wb_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dec_valid_i && dec_ok) state_d = dec_evict_i ? WB : RF;
            WB:      if (wb_ready_i) state_d = RF;
            RF:      if (rf_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dec_ready_o = (state_q == IDLE);
        wb_valid_o  = (state_q == WB);
        rf_valid_o  = (state_q == RF);
        wb_way_o    = wb_valid_o ? way_q     : '0;
        wb_index_o  = wb_valid_o ? index_q   : '0;
        wb_tag_o    = wb_valid_o ? old_tag_q : '0;
        rf_way_o    = rf_valid_o ? way_q     : '0;
        rf_index_o  = rf_valid_o ? index_q   : '0;
        rf_tag_o    = rf_valid_o ? new_tag_q : '0;
        err_o       = err_q;
        wb_cnt_o    = wb_cnt_q;
    end

    always_comb begin
        way_d     = way_q;
        index_d   = index_q;
        old_tag_d = old_tag_q;
        new_tag_d = new_tag_q;
        err_d     = dec_hs & ~dec_ok;
        if (dec_hs && dec_ok) begin
            way_d     = way_enc;
            index_d   = dec_index_i;
            old_tag_d = dec_old_tag_i;
            new_tag_d = dec_new_tag_i;
        end
        // Clear takes priority over a coincident write-back count.
        wb_cnt_d = wb_cnt_q;
        if (ctrl_clr_i)                     wb_cnt_d = '0;
        else if (wb_hs && wb_cnt_q != '1)   wb_cnt_d = wb_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            way_q     <= '0;
            index_q   <= '0;
            old_tag_q <= '0;
            new_tag_q <= '0;
            err_q     <= 1'b0;
            wb_cnt_q  <= '0;
        end else begin
            way_q     <= way_d;
            index_q   <= index_d;
            old_tag_q <= old_tag_d;
            new_tag_q <= new_tag_d;
            err_q     <= err_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_llc_evict_dispatch.sv
// Directed bench: stimulus pushes expected descriptors, a negedge monitor pops and compares.
module tb_axi_llc_evict_dispatch;

    typedef struct packed {
        logic [2:0]  way;
        logic [7:0]  idx;
        logic [19:0] tag;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready, dec_evict;
    logic [7:0]  dec_way_ind, dec_index;
    logic [19:0] dec_old_tag, dec_new_tag;
    logic        wb_valid, wb_ready, rf_valid, rf_ready;
    logic [2:0]  wb_way, rf_way;
    logic [7:0]  wb_index, rf_index;
    logic [19:0] wb_tag, rf_tag;
    logic        err, ctrl_clr;
    logic [31:0] wb_cnt;

    int    vec = 0;
    int    miss = 0;
    int    err_exp = 0;
    desc_t wb_q[$];
    desc_t rf_q[$];
    desc_t held;

    always #5 clk = ~clk;

    axi_llc_evict_dispatch dut (
        .clk_i(clk), .rst_i(rst),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
        .dec_way_ind_i(dec_way_ind), .dec_evict_i(dec_evict),
        .dec_index_i(dec_index), .dec_old_tag_i(dec_old_tag), .dec_new_tag_i(dec_new_tag),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_way_o(wb_way), .wb_index_o(wb_index), .wb_tag_o(wb_tag),
        .rf_valid_o(rf_valid), .rf_ready_i(rf_ready),
        .rf_way_o(rf_way), .rf_index_o(rf_index), .rf_tag_o(rf_tag),
        .err_o(err), .wb_cnt_o(wb_cnt), .ctrl_clr_i(ctrl_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One decision handshake; returns one cycle after the accepting edge.
    task automatic do_dec(input logic [7:0] ind, input logic ev, input logic [7:0] idx,
                          input logic [19:0] ot, input logic [19:0] nt,
                          input logic [2:0] way, input logic ok);
        @(posedge clk); #1;
        dec_valid = 1'b1; dec_way_ind = ind; dec_evict = ev;
        dec_index = idx; dec_old_tag = ot; dec_new_tag = nt;
        if (ok) begin
            if (ev) wb_q.push_back('{way, idx, ot});
            rf_q.push_back('{way, idx, nt});
        end else begin
            err_exp++;
        end
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        desc_t e;
        if (wb_valid && wb_ready) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else begin e = wb_q.pop_front(); chk("wb_desc", {wb_way, wb_index, wb_tag}, e); end
        end
        if (rf_valid && rf_ready) begin
            if (rf_q.size() == 0) chk("rf_unexpected", 1, 0);
            else begin e = rf_q.pop_front(); chk("rf_desc", {rf_way, rf_index, rf_tag}, e); end
        end
        if (wb_valid && rf_valid) chk("both_valid", 1, 0);
        if (!wb_valid && {wb_way, wb_index, wb_tag} != '0) chk("wb_idle_zero", {wb_way, wb_index, wb_tag}, 0);
        if (!rf_valid && {rf_way, rf_index, rf_tag} != '0) chk("rf_idle_zero", {rf_way, rf_index, rf_tag}, 0);
        if (err) begin
            if (err_exp == 0) chk("err_unexpected", 1, 0);
            else err_exp--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_way_ind = '0; dec_evict = 1'b0;
        dec_index = '0; dec_old_tag = '0; dec_new_tag = '0;
        wb_ready = 1'b1; rf_ready = 1'b1; ctrl_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_valids", {wb_valid, rf_valid, err}, 0);
        chk("rst_cnt", wb_cnt, 0);

        // Dirty decision, both readies high.
        do_dec(8'b0000_0100, 1'b1, 8'h3A, 20'h12345, 20'hABCDE, 3'd2, 1'b1);
        @(negedge clk);
        chk("d_wb_n1", {wb_valid, rf_valid, dec_ready}, 3'b100);
        @(negedge clk);
        chk("d_rf_n2", {wb_valid, rf_valid}, 2'b01);
        chk("d_cnt", wb_cnt, 1);
        @(negedge clk);
        chk("d_ready_n3", {dec_ready, rf_valid}, 2'b10);

        // Clean decision goes straight to refill.
        do_dec(8'b1000_0000, 1'b0, 8'h55, 20'h11111, 20'h0F0F0, 3'd7, 1'b1);
        @(negedge clk);
        chk("c_rf_n1", {wb_valid, rf_valid}, 2'b01);
        chk("c_rf_way", rf_way, 7);
        chk("c_cnt", wb_cnt, 1);
        @(negedge clk);
        chk("c_ready", dec_ready, 1);

        // Write-back back-pressure for 5 cycles.
        @(posedge clk); #1 wb_ready = 1'b0;
        do_dec(8'b0000_0010, 1'b1, 8'hC3, 20'h00777, 20'hFEDCB, 3'd1, 1'b1);
        held = '{3'd1, 8'hC3, 20'h00777};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s_wb_valid", {wb_valid, rf_valid, dec_ready}, 3'b100);
            chk("s_wb_stable", {wb_way, wb_index, wb_tag}, held);
        end
        @(posedge clk); #1 wb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s_rf", rf_valid, 1);
        chk("s_cnt", wb_cnt, 2);
        @(negedge clk);
        chk("s_ready", dec_ready, 1);

        // Malformed decisions: multi-hot and zero.
        do_dec(8'b0001_0001, 1'b1, 8'h01, 20'h1, 20'h2, 3'd0, 1'b0);
        @(negedge clk);
        chk("e_pulse", {err, dec_ready, wb_valid, rf_valid}, 4'b1100);
        @(negedge clk);
        chk("e_gone", {err, dec_ready}, 2'b01);
        do_dec(8'b0000_0000, 1'b0, 8'h02, 20'h3, 20'h4, 3'd0, 1'b0);
        @(negedge clk);
        chk("e_zero_pulse", {err, dec_ready, rf_valid}, 3'b110);
        chk("e_cnt", wb_cnt, 2);

        // Saturation from a preloaded counter.
        @(posedge clk); #1 force dut.wb_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1 release dut.wb_cnt_q;
        @(negedge clk);
        chk("sat_preload", wb_cnt, 32'hFFFF_FFFF);
        do_dec(8'b0000_1000, 1'b1, 8'h44, 20'hAAAAA, 20'hBBBBB, 3'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("sat_hold", wb_cnt, 32'hFFFF_FFFF);
        @(negedge clk);

        // Reset while a write-back is pending.
        @(posedge clk); #1 wb_ready = 1'b0;
        do_dec(8'b0010_0000, 1'b1, 8'h66, 20'h5A5A5, 20'hA5A5A, 3'd5, 1'b1);
        @(negedge clk);
        chk("r_in_wb", wb_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        wb_q.delete(); rf_q.delete();
        @(posedge clk); #1 rst = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        chk("r_idle", {dec_ready, wb_valid, rf_valid}, 3'b100);
        chk("r_cnt", wb_cnt, 0);

        // Clear coincident with a write-back handshake.
        do_dec(8'b0100_0000, 1'b1, 8'h77, 20'h13579, 20'h2468A, 3'd6, 1'b1);
        repeat (3) @(negedge clk);
        chk("k_cnt1", wb_cnt, 1);
        @(posedge clk); #1 wb_ready = 1'b0;
        do_dec(8'b0000_0001, 1'b1, 8'h88, 20'h00001, 20'h00002, 3'd0, 1'b1);
        ctrl_clr = 1'b1; wb_ready = 1'b1;
        @(posedge clk); #1 ctrl_clr = 1'b0;
        @(negedge clk);
        chk("k_clr_wins", wb_cnt, 0);
        chk("k_rf", rf_valid, 1);
        @(negedge clk);
        chk("k_ready", dec_ready, 1);

        repeat (2) @(negedge clk);
        chk("end_wb_q", wb_q.size(), 0);
        chk("end_rf_q", rf_q.size(), 0);
        chk("end_err", err_exp, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
